// File: rtl/regfile_pkg.sv
// Shared constants, bus widths and debug FSM encodings for the register file.
package regfile_pkg;

  localparam int unsigned RegNum   = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 32;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  localparam logic [RegDataW-1:0] ZeroWord   = '0;
  localparam logic [RegAddrW-1:0] RegAddrNop = '0;

  typedef logic [RegDataW-1:0] reg_bus_t;
  typedef logic [RegAddrW-1:0] reg_addr_bus_t;

  // Debug access FSM: IDLE waits for a request, EXEC performs it (a write may
  // stall there while the pipeline owns the write port), ACK holds the result
  // until the requester drops dbg_req.
  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_EXEC = 2'd1,
    DBG_ACK  = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read path: zero for disabled reads or x0, write-through bypass from the
// pipeline write port, stored value otherwise.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RegAddrW,
  parameter int unsigned DATA_W = RegDataW
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Priority: zero rule first, then bypass, then storage.
  always_comb begin
    rdata_o = '0;
    if (en_i != ReadEnable || addr_i == '0) begin
      rdata_o = '0;
    end else if (we_i == WriteEnable && waddr_i == addr_i) begin
      rdata_o = wdata_i;
    end else begin
      rdata_o = reg_data_i;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit architectural register file, x0 hardwired to zero, two
// combinational read ports with write-through bypass, one pipeline write port
// and a four-phase req/ack debug port that yields to the pipeline writer.
//
// Debug handshake (four-phase, level signals):
//   requester raises dbg_req with dbg_we/dbg_addr/dbg_wdata stable; the block
//   raises dbg_ack once the operation is done (dbg_rdata valid while ack is
//   high); requester drops dbg_req; the block drops dbg_ack on the next edge.
//   Requests seen outside IDLE are ignored.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned REG_NUM = RegNum,
  parameter int unsigned ADDR_W  = RegAddrW,
  parameter int unsigned DATA_W  = RegDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] regs_q [REG_NUM];

  dbg_state_e        state_q;
  logic              cap_we_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_wdata_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_d;

  logic pipe_wr;
  logic dbg_wr;

  // Pipeline writes to x0 are dropped; a debug write only lands in EXEC when
  // the pipeline is not writing, so the two never collide on one edge.
  assign pipe_wr = (we == WriteEnable) && (waddr != '0);
  assign dbg_wr  = (state_q == DBG_EXEC) && cap_we_q && !we && (cap_addr_q != '0);

  // Storage array: cleared on reset, pipeline or debug write on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (pipe_wr) begin
        regs_q[waddr] <= wdata;
      end
      if (dbg_wr) begin
        regs_q[cap_addr_q] <= cap_wdata_q;
      end
    end
  end

  // Read port 1; enable is masked during reset so the output reads zero even
  // if the bypass would otherwise forward write data.
  regfile_rdport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd1 (
    .en_i       (re1 & ~rst),
    .addr_i     (raddr1),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .reg_data_i (regs_q[raddr1]),
    .rdata_o    (rdata1)
  );

  // Read port 2, same rules as port 1.
  regfile_rdport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd2 (
    .en_i       (re2 & ~rst),
    .addr_i     (raddr2),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .reg_data_i (regs_q[raddr2]),
    .rdata_o    (rdata2)
  );

  // Debug read path on the captured address, sampled into dbg_rdata in EXEC.
  regfile_rdport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_dbg (
    .en_i       (ReadEnable),
    .addr_i     (cap_addr_q),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .reg_data_i (regs_q[cap_addr_q]),
    .rdata_o    (dbg_rdata_d)
  );

  // Debug FSM with registered ack and read data; reset abandons any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= DBG_IDLE;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= RegAddrNop[ADDR_W-1:0];
      cap_wdata_q <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      case (state_q)
        DBG_IDLE: begin
          if (dbg_req) begin
            cap_we_q    <= dbg_we;
            cap_addr_q  <= dbg_addr;
            cap_wdata_q <= dbg_wdata;
            state_q     <= DBG_EXEC;
          end
        end
        DBG_EXEC: begin
          if (!cap_we_q) begin
            dbg_rdata_q <= dbg_rdata_d;
            dbg_ack_q   <= 1'b1;
            state_q     <= DBG_ACK;
          end else if (!we) begin
            dbg_ack_q <= 1'b1;
            state_q   <= DBG_ACK;
          end
        end
        DBG_ACK: begin
          if (!dbg_req) begin
            dbg_ack_q <= 1'b0;
            state_q   <= DBG_IDLE;
          end
        end
        default: begin
          dbg_ack_q <= 1'b0;
          state_q   <= DBG_IDLE;
        end
      endcase
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: drivers push expected values into a scoreboard
// queue, a negedge monitor pops and compares against the selected DUT output.
module tb_regfile;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [1:0] SEL_RD1  = 2'd0;
  localparam logic [1:0] SEL_RD2  = 2'd1;
  localparam logic [1:0] SEL_ACK  = 2'd2;
  localparam logic [1:0] SEL_DBGD = 2'd3;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;

  logic [DW-1:0] exp_q[$];
  logic [1:0]    sel_q[$];
  string         name_q[$];

  int checks;
  int errors;

  regfile dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every expectation pushed since the last negedge is
  // compared against the live DUT output at this negedge.
  always @(negedge clk) begin
    logic [DW-1:0] exp_v;
    logic [DW-1:0] act_v;
    logic [1:0]    sel_v;
    string         nm;
    while (sel_q.size() > 0) begin
      sel_v = sel_q.pop_front();
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      case (sel_v)
        SEL_RD1:  act_v = rdata1;
        SEL_RD2:  act_v = rdata2;
        SEL_ACK:  act_v = {{(DW-1){1'b0}}, dbg_ack};
        default:  act_v = dbg_rdata;
      endcase
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", nm, act_v, exp_v, $time);
      end
    end
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [1:0] sel, input logic [DW-1:0] val, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(val);
    name_q.push_back(nm);
  endtask

  task automatic pipe_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic dbg_start(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = 1'b1; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    checks = 0; errors = 0;

    // Reset state
    step();
    step();
    expect_out(SEL_ACK,  32'h0, "reset_ack");
    expect_out(SEL_DBGD, 32'h0, "reset_dbg_rdata");
    rst = 1'b0;
    step();

    // Write x5, read back, then reset mid-run clears it
    pipe_write(5'd5, 32'h0000_0099);
    re1 = 1'b1; raddr1 = 5'd5;
    expect_out(SEL_RD1, 32'h0000_0099, "x5_before_reset");
    step();
    rst = 1'b1;
    expect_out(SEL_RD1, 32'h0, "rdata1_during_reset");
    step();
    rst = 1'b0;
    expect_out(SEL_RD1, 32'h0, "x5_after_reset");
    step();

    // Write x5 with same-cycle bypass, then from storage
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
    expect_out(SEL_RD1, 32'h1234_5678, "x5_bypass");
    step();
    we = 1'b0;
    expect_out(SEL_RD1, 32'h1234_5678, "x5_stored");
    step();

    // x0 protection via pipeline write
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
    expect_out(SEL_RD1, 32'h0, "x0_bypass_blocked");
    step();
    we = 1'b0;
    expect_out(SEL_RD1, 32'h0, "x0_after_write");
    step();

    // Bypass on port 2, then enable gating, then stored value
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; re2 = 1'b1; raddr2 = 5'd7;
    expect_out(SEL_RD2, 32'hA5A5_A5A5, "x7_bypass_rd2");
    step();
    re2 = 1'b0;
    expect_out(SEL_RD2, 32'h0, "rd2_disabled");
    step();
    we = 1'b0; re2 = 1'b1;
    expect_out(SEL_RD2, 32'hA5A5_A5A5, "x7_stored_rd2");
    step();

    // Debug read of x3: ack two edges after request, held until req drops
    pipe_write(5'd3, 32'hDEAD_BEEF);
    dbg_start(1'b0, 5'd3, 32'h0);
    expect_out(SEL_ACK, 32'h0, "dbg_rd_ack_idle");
    step();
    expect_out(SEL_ACK, 32'h0, "dbg_rd_ack_exec");
    step();
    expect_out(SEL_ACK,  32'h1,         "dbg_rd_ack_up");
    expect_out(SEL_DBGD, 32'hDEAD_BEEF, "dbg_rd_data");
    step();
    expect_out(SEL_ACK, 32'h1, "dbg_rd_ack_hold");
    dbg_req = 1'b0;
    expect_out(SEL_ACK, 32'h1, "dbg_rd_ack_before_fall");
    step();
    expect_out(SEL_ACK,  32'h0,         "dbg_rd_ack_fall");
    expect_out(SEL_DBGD, 32'hDEAD_BEEF, "dbg_rd_data_kept");
    step();

    // Debug read concurrent with pipeline write to same address in EXEC
    dbg_start(1'b0, 5'd3, 32'h0);
    step();
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D;
    step();
    we = 1'b0;
    expect_out(SEL_ACK,  32'h1,         "dbg_rd_bypass_ack");
    expect_out(SEL_DBGD, 32'hCAFE_F00D, "dbg_rd_bypass_data");
    dbg_req = 1'b0;
    step();
    step();

    // Debug write to x0: acked, x0 still zero
    dbg_start(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    step();
    expect_out(SEL_ACK, 32'h1, "dbg_wr_x0_ack");
    dbg_req = 1'b0;
    step();
    re1 = 1'b1; raddr1 = 5'd0;
    expect_out(SEL_RD1, 32'h0, "dbg_wr_x0_read");
    step();

    // Debug write stalled by four cycles of pipeline writes to x9
    dbg_start(1'b1, 5'd9, 32'h0000_0011);
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0022;
    for (int i = 0; i < 4; i++) begin
      expect_out(SEL_ACK, 32'h0, "dbg_wr_stall_no_ack");
      step();
    end
    we = 1'b0;
    raddr1 = 5'd9;
    expect_out(SEL_ACK, 32'h0, "dbg_wr_stall_exec");
    expect_out(SEL_RD1, 32'h0000_0022, "x9_pipe_value");
    step();
    expect_out(SEL_ACK, 32'h1,         "dbg_wr_stall_ack");
    expect_out(SEL_RD1, 32'h0000_0011, "x9_final_dbg_value");
    dbg_req = 1'b0;
    step();
    step();

    // Reset mid-handshake: stalled debug write to x4 must not land
    dbg_start(1'b1, 5'd4, 32'h0000_0055);
    we = 1'b1; waddr = 5'd10; wdata = 32'h0000_0001;
    step();
    step();
    rst = 1'b1;
    expect_out(SEL_ACK, 32'h0, "rst_mid_ack");
    we = 1'b0; dbg_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    raddr1 = 5'd4;
    expect_out(SEL_RD1, 32'h0, "x4_not_written");
    raddr1 = 5'd4;
    step();

    // New request after reset works normally
    dbg_start(1'b1, 5'd4, 32'h0000_0066);
    step();
    step();
    expect_out(SEL_ACK, 32'h1,         "post_rst_dbg_ack");
    expect_out(SEL_RD1, 32'h0000_0066, "x4_post_rst_write");
    dbg_req = 1'b0;
    step();
    expect_out(SEL_ACK, 32'h0, "post_rst_ack_fall");
    step();

    // Drain: any expectation never compared counts as an error
    @(negedge clk);
    #1;
    if (sel_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sel_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
